// File: rtl/rng_req_arbiter.sv
// rng_req_arbiter
//   Shares one random_num_gen instance between NREQ requesters. Level
//   requests are arbitrated round-robin. The winner gets one registered
//   start pulse sent to the generator. The arbiter then waits for the
//   generator's completion pulse and hands the captured word back to the
//   winner with a one-cycle ack. A watchdog ends a hung generation: it
//   delivers a zero word with err set.
//
// Ports
//   clk           clock
//   rst_n         asynchronous reset, active-low
//   req           per-requester level request, held until its ack
//   ack           one-hot, one-cycle pulse: result for requester i is valid
//   rnd_data      delivered random word, held until the next delivery
//   err           valid with ack; 1 = generator timed out (rnd_data = 0)
//   busy          high whenever the arbiter is not idle
//   rng_enable_p  start pulse to the generator
//   rng_done_p    completion pulse from the generator
//   rng_y         result word from the generator
module rng_req_arbiter #(
  parameter int NBITS   = 256,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  ack,
  output logic [NBITS-1:0] rnd_data,
  output logic             err,
  output logic             busy,
  output logic             rng_enable_p,
  input  logic             rng_done_p,
  input  logic [NBITS-1:0] rng_y
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t          state_reg;
  logic [IW-1:0]   grant_reg;
  logic [IW-1:0]   last_grant_reg;
  logic [IW-1:0]   grant_next;
  logic [TW-1:0]   timer_reg;

  // Candidate index k positions after the last winner, wrapping modulo NREQ.
  // The wrap uses an explicit modulo so that NREQ need not be a power of two.
  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
    int sum;
    sum = (int'(base) + k) % NREQ;
    return IW'(sum);
  endfunction

  // Round-robin pick. The scan runs from the farthest candidate down to the
  // nearest one, so the last assignment comes from the requester closest
  // after last_grant. If nothing is requested, the value is unused.
  always_comb begin
    grant_next = last_grant_reg;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[rr_index(last_grant_reg, k)]) begin
        grant_next = rr_index(last_grant_reg, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ack            <= '0;
      err            <= 1'b0;
      busy           <= 1'b0;
      rng_enable_p   <= 1'b0;
      rnd_data       <= '0;
      timer_reg      <= '0;
      grant_reg      <= '0;
      last_grant_reg <= IW'(NREQ - 1);
    end else begin
      // ack, err and the start pulse are single-cycle strobes.
      ack          <= '0;
      err          <= 1'b0;
      rng_enable_p <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant_reg    <= grant_next;
            rng_enable_p <= 1'b1;
            busy         <= 1'b1;
            state_reg    <= START;
          end
        end
        START: begin
          // A completion pulse here belongs to no run of ours, so it is ignored.
          timer_reg <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          timer_reg <= timer_reg + TW'(1);
          // If done arrives on the same edge as the timeout, done takes priority.
          if (rng_done_p) begin
            rnd_data  <= rng_y;
            ack       <= NREQ'(1) << grant_reg;
            state_reg <= DELIVER;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            rnd_data  <= '0;
            err       <= 1'b1;
            ack       <= NREQ'(1) << grant_reg;
            state_reg <= DELIVER;
          end
        end
        DELIVER: begin
          last_grant_reg <= grant_reg;
          busy           <= 1'b0;
          state_reg      <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_req_arbiter.sv
// tb_rng_req_arbiter
//   Directed bench for rng_req_arbiter (NBITS=256, NREQ=4, TIMEOUT=16).
//   The reference model is timestamp based. It records the edge of each
//   grant and derives every expected strobe from that edge number.
//   Directed literal checks pin down the exact latencies.
module tb_rng_req_arbiter;

  localparam int NBITS   = 256;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       req = 4'b0000;
  logic [3:0]       ack;
  logic [NBITS-1:0] rnd_data;
  logic             err;
  logic             busy;
  logic             rng_enable_p;
  logic             rng_done_p = 1'b0;
  logic [NBITS-1:0] rng_y = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rng_req_arbiter #(
    .NBITS  (NBITS),
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .ack         (ack),
    .rnd_data    (rnd_data),
    .err         (err),
    .busy        (busy),
    .rng_enable_p(rng_enable_p),
    .rng_done_p  (rng_done_p),
    .rng_y       (rng_y)
  );

  // ---------------- reference model ----------------
  int               e_cnt = 0;     // index of the current rising edge
  int               g_edge = 0;    // edge where the current grant was made
  bit               active = 0;    // a grant is outstanding
  bit               resolved = 0;  // its result has been delivered
  logic [1:0]       owner = 2'd0;
  logic [1:0]       last = 2'd3;
  logic [3:0]       x_ack = 4'b0;
  logic             x_err = 1'b0;
  logic             x_en = 1'b0;
  logic             x_busy = 1'b0;
  logic [NBITS-1:0] x_data = '0;

  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] c;
    for (int k = 1; k <= 4; k++) begin
      c = l + 2'(k);
      if (r[c]) return c;
    end
    return l;
  endfunction

  // Grant at edge G. The enable pulse follows G. Done is accepted on edges
  // G+2 .. G+1+TIMEOUT, and the last of those edges is also the timeout.
  // The grant is released one edge after delivery.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_cnt <= 0; g_edge <= 0; active <= 0; resolved <= 0;
      owner <= 2'd0; last <= 2'd3;
      x_ack <= 4'b0; x_err <= 1'b0; x_en <= 1'b0; x_busy <= 1'b0; x_data <= '0;
    end else begin
      e_cnt <= e_cnt + 1;
      x_ack <= 4'b0; x_err <= 1'b0; x_en <= 1'b0;
      if (!active) begin
        if (req != 4'b0) begin
          active   <= 1;
          resolved <= 0;
          owner    <= pick(req, last);
          g_edge   <= e_cnt;
          x_en     <= 1'b1;
          x_busy   <= 1'b1;
        end
      end else if (!resolved) begin
        if (e_cnt >= g_edge + 2 && rng_done_p) begin
          resolved <= 1;
          x_data   <= rng_y;
          x_ack    <= 4'b0001 << owner;
        end else if (e_cnt == g_edge + 1 + TIMEOUT) begin
          resolved <= 1;
          x_data   <= '0;
          x_err    <= 1'b1;
          x_ack    <= 4'b0001 << owner;
        end
      end else begin
        active <= 0;
        x_busy <= 1'b0;
        last   <= owner;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, want);
    end
  endtask

  // One clock: compare the DUT against the model on the falling edge, then
  // leave 1 time unit so that the caller can drive the inputs.
  task automatic step();
    @(negedge clk);
    chk("cyc_ack",  NBITS'(ack),          NBITS'(x_ack));
    chk("cyc_en",   NBITS'(rng_enable_p), NBITS'(x_en));
    chk("cyc_err",  NBITS'(err),          NBITS'(x_err));
    chk("cyc_busy", NBITS'(busy),         NBITS'(x_busy));
    chk("cyc_data", rnd_data,             x_data);
    #1;
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!rng_enable_p && n < 10) begin
      step();
      n++;
    end
    if (!rng_enable_p) begin
      total++;
      bad++;
      $display("FAIL enable_timeout: rng_enable_p=%0b required 1", rng_enable_p);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (ack == 4'b0 && n < 40) begin
      step();
      n++;
    end
    if (ack == 4'b0) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: ack=%0h required nonzero", ack);
    end else begin
      $display("txn: ack=%b err=%0b data=%0h after %0d cycles", ack, err, rnd_data, n);
    end
  endtask

  // Behavioural generator: answers the start pulse after 'delay' cycles,
  // or never when 'hang' is set.
  task automatic run_rng(input int delay, input logic [NBITS-1:0] yv, input bit hang);
    wait_en();
    if (!hang) begin
      repeat (delay - 1) step();
      rng_done_p = 1'b1;
      rng_y = yv;
      step();
      rng_done_p = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [3:0] want;

    // Reset state
    step();
    step();
    chk("rst_ack",  NBITS'(ack),          NBITS'(4'b0));
    chk("rst_busy", NBITS'(busy),         NBITS'(1'b0));
    chk("rst_en",   NBITS'(rng_enable_p), NBITS'(1'b0));
    chk("rst_data", rnd_data,             NBITS'(0));
    rst_n = 1'b1;
    step();

    // 1: single request, done 5 cycles after enable
    req = 4'b0010;
    step();
    chk("t1_en_latency", NBITS'(rng_enable_p), NBITS'(1'b1));
    run_rng(5, NBITS'(8'hA5), 1'b0);
    chk("t1_ack",  NBITS'(ack), NBITS'(4'b0010));
    chk("t1_err",  NBITS'(err), NBITS'(1'b0));
    chk("t1_data", rnd_data,    NBITS'(8'hA5));
    wait_ack(n);
    req = 4'b0000;
    step();
    chk("t1_idle", NBITS'(busy), NBITS'(1'b0));

    // 2: all requesting, rotate 0,1,2,3,0
    pulse_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      run_rng(2, NBITS'(i + 16), 1'b0);
      wait_ack(n);
      want = 4'b0001 << (i % 4);
      chk("t2_order", NBITS'(ack), NBITS'(want));
      chk("t2_data",  rnd_data,    NBITS'(i + 16));
      if (i == 4) req = 4'b0000;
      step();
      chk("t2_gap_busy", NBITS'(busy), NBITS'(1'b0));
    end

    // 3: generator hangs -> timeout after 16 WAIT cycles
    req = 4'b0001;
    run_rng(0, '0, 1'b1);
    wait_ack(n);
    chk("t3_latency", NBITS'(n),   NBITS'(17));
    chk("t3_ack",     NBITS'(ack), NBITS'(4'b0001));
    chk("t3_err",     NBITS'(err), NBITS'(1'b1));
    chk("t3_data",    rnd_data,    NBITS'(0));
    req = 4'b0000;
    step();
    req = 4'b0100;
    run_rng(3, NBITS'(16'h1234), 1'b0);
    wait_ack(n);
    chk("t3_next_ack",  NBITS'(ack), NBITS'(4'b0100));
    chk("t3_next_err",  NBITS'(err), NBITS'(1'b0));
    chk("t3_next_data", rnd_data,    NBITS'(16'h1234));
    req = 4'b0000;
    step();

    // 4: reset during WAIT
    req = 4'b1000;
    wait_en();
    step();
    step();
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("t4_async_busy", NBITS'(busy), NBITS'(1'b0));
    chk("t4_async_ack",  NBITS'(ack),  NBITS'(4'b0));
    chk("t4_async_data", rnd_data,     NBITS'(0));
    step();
    step();
    rst_n = 1'b1;
    step();
    rng_done_p = 1'b1;
    rng_y = NBITS'(16'hDEAD);
    step();
    rng_done_p = 1'b0;
    chk("t4_stale_ack",  NBITS'(ack),  NBITS'(4'b0));
    chk("t4_stale_busy", NBITS'(busy), NBITS'(1'b0));
    req = 4'b1001;
    run_rng(2, NBITS'(16'hBEEF), 1'b0);
    wait_ack(n);
    chk("t4_first_grant", NBITS'(ack), NBITS'(4'b0001));
    req = 4'b1000;
    step();
    run_rng(2, NBITS'(16'hCAFE), 1'b0);
    wait_ack(n);
    chk("t4_second_grant", NBITS'(ack), NBITS'(4'b1000));
    chk("t4_second_data",  rnd_data,    NBITS'(16'hCAFE));
    req = 4'b0000;
    step();

    // 5: stray done pulses in IDLE and START
    rng_done_p = 1'b1;
    step();
    rng_done_p = 1'b0;
    step();
    chk("t5_idle_busy", NBITS'(busy), NBITS'(1'b0));
    req = 4'b0010;
    step();
    chk("t5_en", NBITS'(rng_enable_p), NBITS'(1'b1));
    rng_done_p = 1'b1;
    rng_y = NBITS'(16'hDEAD);
    step();
    rng_done_p = 1'b0;
    step();
    step();
    chk("t5_still_wait_ack",  NBITS'(ack),  NBITS'(4'b0));
    chk("t5_still_wait_busy", NBITS'(busy), NBITS'(1'b1));
    rng_done_p = 1'b1;
    rng_y = NBITS'(77);
    step();
    rng_done_p = 1'b0;
    chk("t5_ack",  NBITS'(ack), NBITS'(4'b0010));
    chk("t5_data", rnd_data,    NBITS'(77));
    wait_ack(n);
    req = 4'b0000;
    step();

    // 6: requester drops during WAIT; done arrives on the timeout edge
    req = 4'b0100;
    step();
    step();
    req = 4'b0000;
    repeat (15) step();
    rng_done_p = 1'b1;
    rng_y = NBITS'(16'h5A5A);
    step();
    rng_done_p = 1'b0;
    chk("t6_ack",  NBITS'(ack), NBITS'(4'b0100));
    chk("t6_err",  NBITS'(err), NBITS'(1'b0));
    chk("t6_data", rnd_data,    NBITS'(16'h5A5A));
    wait_ack(n);
    req = 4'b1011;
    run_rng(2, NBITS'(8'h11), 1'b0);
    wait_ack(n);
    chk("t6_next_rr", NBITS'(ack), NBITS'(4'b1000));
    req = 4'b0000;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
